// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 memory-interface types and helpers
// Provides word_t, be_t, mem_op_t (load/store kinds), the NOP instruction,
// the TCM data-FSM state type, and lane-mask / load-extension helpers.
package riscv;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_t;

    localparam word_t NOP = 32'h00000013;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } tcm_state_t;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Lanes touched by an access when it starts at lane 0.
    function automatic be_t op_mask(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 4'b0001;
            MEM_LH, MEM_LHU, MEM_SH: return 4'b0011;
            default:                 return 4'b1111;
        endcase
    endfunction

    // v holds the loaded bytes right-justified.
    function automatic word_t load_extend(input mem_op_t op, input word_t v);
        case (op)
            MEM_LB:  return {{24{v[7]}}, v[7:0]};
            MEM_LBU: return {24'h000000, v[7:0]};
            MEM_LH:  return {{16{v[15]}}, v[15:0]};
            MEM_LHU: return {16'h0000, v[15:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/tcm_if.sv
// rtl/tcm_if.sv - TCM data + instruction-fetch port bundle
// master: core side (drives requests); slave: tcm side (drives grant/responses).
// Data: d_req/d_gnt/d_op/d_addr/d_wdata -> d_rvalid/d_rdata/d_error.
// Fetch: i_req/i_addr -> i_rvalid/i_rdata/i_error.
interface tcm_if;
    import riscv::*;

    logic    d_req;
    logic    d_gnt;
    mem_op_t d_op;
    word_t   d_addr;
    word_t   d_wdata;
    logic    d_rvalid;
    word_t   d_rdata;
    logic    d_error;

    logic    i_req;
    word_t   i_addr;
    logic    i_rvalid;
    word_t   i_rdata;
    logic    i_error;

    modport master (
        output d_req, d_op, d_addr, d_wdata, i_req, i_addr,
        input  d_gnt, d_rvalid, d_rdata, d_error, i_rvalid, i_rdata, i_error
    );

    modport slave (
        input  d_req, d_op, d_addr, d_wdata, i_req, i_addr,
        output d_gnt, d_rvalid, d_rdata, d_error, i_rvalid, i_rdata, i_error
    );

endinterface

// File: rtl/tcm_ram.sv
// rtl/tcm_ram.sv - true dual-port inferred RAM, per-byte write enables
// Port a: read/write (a_addr, a_be, a_wdata -> a_rdata), read-first.
// Port b: read-only (b_addr -> b_rdata); a same-cycle write on port a is not
// visible on port b until the following read.
// INIT_FILE names the intended initial contents image for the target flow.
module tcm_ram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = "boot.mem"
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    input  logic [WIDTH/8-1:0]       a_be,
    input  logic [WIDTH-1:0]         a_wdata,
    output logic [WIDTH-1:0]         a_rdata,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    output logic [WIDTH-1:0]         b_rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (a_be[i]) begin
                mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
        a_rdata_q <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        b_rdata_q <= mem[b_addr];
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/tcm.sv
// rtl/tcm.sv - parametrised tightly-coupled memory for the RV32 core
// Ports: clk, resetn (async, active-low), bus (tcm_if.slave: data port with
// request/grant/response handshake, pipelined read-only fetch port).
// Build option TCM_MISALIGNED_EN: split lane-crossing data accesses into two
// RAM beats; when undefined, unnatural alignments return d_error instead.
module tcm
    import riscv::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter word_t BASE_ADDR  = 32'h00000000,
    parameter        INIT_FILE  = "boot.mem"
) (
    input  logic  clk,
    input  logic  resetn,
    tcm_if.slave  bus
);
    typedef logic [ADDR_WIDTH-1:0] widx_t;

    tcm_state_t state_q, state_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rsp_split_q, rsp_split_d;
    mem_op_t    rsp_op_q, rsp_op_d;
    logic [1:0] rsp_lane_q, rsp_lane_d;
    word_t      lo_q, lo_d;
    widx_t      split_widx_q, split_widx_d;
    be_t        split_be_q, split_be_d;
    word_t      split_wdata_q, split_wdata_d;
    logic       i_valid_q, i_valid_d;
    logic       i_err_q, i_err_d;

    word_t       off, i_off;
    logic [1:0]  lane;
    widx_t       widx, ram_addr;
    be_t         ram_be;
    word_t       ram_wdata, ram_rdata, ram_b_rdata;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide, rd_wide;
    logic        oor, oor_nxt, crossing, mis_err, err, gnt, accept;

    tcm_ram #(
        .WIDTH     (32),
        .DEPTH     (1 << ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .a_addr  (ram_addr),
        .a_be    (ram_be),
        .a_wdata (ram_wdata),
        .a_rdata (ram_rdata),
        .b_addr  (i_off[ADDR_WIDTH+1:2]),
        .b_rdata (ram_b_rdata)
    );

    // Decode: the access is viewed as a 64-bit window over words A and A+1;
    // whatever lands in the upper half belongs to the second beat.
    always_comb begin
        off      = bus.d_addr - BASE_ADDR;
        lane     = off[1:0];
        widx     = off[ADDR_WIDTH+1:2];
        be_wide  = {4'b0000, op_mask(bus.d_op)} << lane;
        wd_wide  = {32'h00000000, bus.d_wdata} << {lane, 3'b000};
        oor      = |off[31:ADDR_WIDTH+2];
        // A+1 leaves the window only when A is the last word.
        oor_nxt  = oor || (widx == '1);
`ifdef TCM_MISALIGNED_EN
        crossing = |be_wide[7:4];
        mis_err  = 1'b0;
`else
        crossing = 1'b0;
        mis_err  = |be_wide[7:4] || ((op_mask(bus.d_op) == 4'b0011) && lane[0]);
`endif
        err      = oor || (crossing && oor_nxt) || mis_err;
        gnt      = resetn && (state_q == ST_IDLE);
        accept   = bus.d_req && gnt;
    end

    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_split_d   = 1'b0;
        rsp_op_d      = rsp_op_q;
        rsp_lane_d    = rsp_lane_q;
        lo_d          = lo_q;
        split_widx_d  = split_widx_q;
        split_be_d    = split_be_q;
        split_wdata_d = split_wdata_q;
        ram_addr      = widx;
        ram_be        = 4'b0000;
        ram_wdata     = wd_wide[31:0];
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_op_d   = bus.d_op;
                    rsp_lane_d = lane;
                    if (err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        if (op_is_store(bus.d_op)) begin
                            ram_be = be_wide[3:0];
                        end
                        if (crossing) begin
                            state_d       = ST_SPLIT;
                            split_widx_d  = widx + 1'b1;
                            split_be_d    = op_is_store(bus.d_op) ? be_wide[7:4] : 4'b0000;
                            split_wdata_d = wd_wide[63:32];
                        end else begin
                            rsp_valid_d = 1'b1;
                        end
                    end
                end
            end
            ST_SPLIT: begin
                // ram_rdata now holds word A from the first beat.
                ram_addr    = split_widx_q;
                ram_be      = split_be_q;
                ram_wdata   = split_wdata_q;
                lo_d        = ram_rdata;
                rsp_valid_d = 1'b1;
                rsp_split_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i_off     = bus.i_addr - BASE_ADDR;
        i_valid_d = bus.i_req;
        i_err_d   = bus.i_req && ((i_off[1:0] != 2'b00) || (|i_off[31:ADDR_WIDTH+2]));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_split_q   <= 1'b0;
            rsp_op_q      <= MEM_LW;
            rsp_lane_q    <= 2'b00;
            lo_q          <= '0;
            split_widx_q  <= '0;
            split_be_q    <= '0;
            split_wdata_q <= '0;
            i_valid_q     <= 1'b0;
            i_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_split_q   <= rsp_split_d;
            rsp_op_q      <= rsp_op_d;
            rsp_lane_q    <= rsp_lane_d;
            lo_q          <= lo_d;
            split_widx_q  <= split_widx_d;
            split_be_q    <= split_be_d;
            split_wdata_q <= split_wdata_d;
            i_valid_q     <= i_valid_d;
            i_err_q       <= i_err_d;
        end
    end

    always_comb begin
        rd_wide = rsp_split_q ? {ram_rdata, lo_q} : {32'h00000000, ram_rdata};
        rd_wide = rd_wide >> {rsp_lane_q, 3'b000};
    end

    assign bus.d_gnt    = gnt;
    assign bus.d_rvalid = rsp_valid_q;
    assign bus.d_error  = rsp_valid_q && rsp_err_q;
    assign bus.d_rdata  = (rsp_valid_q && !rsp_err_q && !op_is_store(rsp_op_q))
                          ? load_extend(rsp_op_q, rd_wide[31:0]) : 32'h00000000;
    assign bus.i_rvalid = i_valid_q;
    assign bus.i_error  = i_valid_q && i_err_q;
    assign bus.i_rdata  = (i_valid_q && !i_err_q) ? ram_b_rdata : NOP;

endmodule

// File: tb/tb_tcm.sv
// tb/tb_tcm.sv - directed self-checking bench for tcm
module tb_tcm;
    import riscv::*;

    localparam word_t BASE = 32'h00001000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    tcm_if bus ();

    tcm #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (BASE),
        .INIT_FILE  ("")
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic d_one(input mem_op_t op, input word_t off, input word_t wd,
                         output logic gnt, output logic rv, output word_t rd, output logic er);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_op = op; bus.d_addr = BASE + off; bus.d_wdata = wd;
        gnt = bus.d_gnt;
        @(negedge clk);
        bus.d_req = 1'b0;
        rv = bus.d_rvalid; rd = bus.d_rdata; er = bus.d_error;
    endtask

    task automatic d_split(input mem_op_t op, input word_t off, input word_t wd,
                           output logic gnt1, output logic gnt2, output logic rv1,
                           output logic rv2, output word_t rd, output logic er);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_op = op; bus.d_addr = BASE + off; bus.d_wdata = wd;
        gnt1 = bus.d_gnt;
        @(negedge clk);
        bus.d_req = 1'b0;
        gnt2 = bus.d_gnt; rv1 = bus.d_rvalid;
        @(negedge clk);
        rv2 = bus.d_rvalid; rd = bus.d_rdata; er = bus.d_error;
    endtask

    task automatic f_one(input word_t addr, output logic rv, output word_t rd, output logic er);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = addr;
        @(negedge clk);
        bus.i_req = 1'b0;
        rv = bus.i_rvalid; rd = bus.i_rdata; er = bus.i_error;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 7;
        if (bus.d_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b want=0", bus.d_gnt); end
        if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", bus.d_rvalid); end
        if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.d_rdata); end
        if (bus.d_error !== 1'b0) begin bad++; $display("FAIL rst_derr got=%b want=0", bus.d_error); end
        if (bus.i_rvalid !== 1'b0) begin bad++; $display("FAIL rst_irvalid got=%b want=0", bus.i_rvalid); end
        if (bus.i_rdata !== 32'h00000013) begin bad++; $display("FAIL rst_irdata got=%h want=00000013", bus.i_rdata); end
        if (bus.i_error !== 1'b0) begin bad++; $display("FAIL rst_ierr got=%b want=0", bus.i_error); end
        resetn = 1'b1;
        #1;
        total++;
        if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL rel_gnt got=%b want=1", bus.d_gnt); end
    endtask

    task automatic test_word_byte();
        logic g, rv, er; word_t rd;
        d_one(MEM_SW, 32'h10, 32'hDEADBEEF, g, rv, rd, er);
        total++;
        if ({g, rv, er, rd} !== {3'b110, 32'h0}) begin bad++; $display("FAIL sw10 got g/rv/er/rd=%b%b%b/%h want 110/0", g, rv, er, rd); end
        d_one(MEM_LW, 32'h10, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL lw10 got rv/er/rd=%b%b/%h want 10/deadbeef", rv, er, rd); end
        d_one(MEM_LB, 32'h13, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb13 got=%h want=ffffffde", rd); end
        d_one(MEM_LBU, 32'h13, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'h000000DE) begin bad++; $display("FAIL lbu13 got=%h want=000000de", rd); end
    endtask

    task automatic test_half();
        logic g, rv, er; word_t rd;
        d_one(MEM_SW, 32'h20, 32'h12345678, g, rv, rd, er);
        d_one(MEM_SH, 32'h22, 32'h00008001, g, rv, rd, er);
        d_one(MEM_LH, 32'h22, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh22 got=%h want=ffff8001", rd); end
        d_one(MEM_LHU, 32'h22, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu22 got=%h want=00008001", rd); end
        d_one(MEM_LW, 32'h20, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'h80015678) begin bad++; $display("FAIL lw20 got=%h want=80015678", rd); end
        d_one(MEM_SB, 32'h21, 32'h000000AA, g, rv, rd, er);
        d_one(MEM_LW, 32'h20, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'h8001AA78) begin bad++; $display("FAIL lw20_sb got=%h want=8001aa78", rd); end
        d_one(MEM_LB, 32'h21, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb21 got=%h want=ffffffaa", rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_op = MEM_LW; bus.d_addr = BASE + 32'h10;
        @(negedge clk);
        total++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL b2b_0 got rv/rd=%b/%h want 1/deadbeef", bus.d_rvalid, bus.d_rdata); end
        bus.d_addr = BASE + 32'h20;
        total++;
        if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt got=%b want=1", bus.d_gnt); end
        @(negedge clk);
        total++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h8001AA78}) begin bad++; $display("FAIL b2b_1 got rv/rd=%b/%h want 1/8001aa78", bus.d_rvalid, bus.d_rdata); end
        bus.d_op = MEM_LBU; bus.d_addr = BASE + 32'h10;
        @(negedge clk);
        total++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h000000EF}) begin bad++; $display("FAIL b2b_2 got rv/rd=%b/%h want 1/000000ef", bus.d_rvalid, bus.d_rdata); end
        bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", bus.d_rvalid); end
    endtask

    task automatic test_range();
        logic g, rv, er; word_t rd;
        d_one(MEM_LW, 32'h1000, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL oor_hi got rv/er/rd=%b%b/%h want 11/0", rv, er, rd); end
        d_one(MEM_LW, 32'hFFFFFFFC, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL oor_lo got rv/er/rd=%b%b/%h want 11/0", rv, er, rd); end
        d_one(MEM_SW, 32'h1010, 32'h00000BAD, g, rv, rd, er);
        total++;
        if ({rv, er} !== 2'b11) begin bad++; $display("FAIL oor_sw got rv/er=%b%b want 11", rv, er); end
        d_one(MEM_LW, 32'h10, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_nowrite got=%h want=deadbeef", rd); end
        d_one(MEM_SW, 32'hFFC, 32'h5A5AA5A5, g, rv, rd, er);
        d_one(MEM_LW, 32'hFFC, 32'h0, g, rv, rd, er);
        total++;
        if ({er, rd} !== {1'b0, 32'h5A5AA5A5}) begin bad++; $display("FAIL lastword got er/rd=%b/%h want 0/5a5aa5a5", er, rd); end
    endtask

    task automatic test_fetch();
        logic rv, er; word_t rd;
        f_one(BASE + 32'h10, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL f10 got rv/er/rd=%b%b/%h want 10/deadbeef", rv, er, rd); end
        f_one(BASE + 32'h1000, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h00000013}) begin bad++; $display("FAIL f_oor got rv/er/rd=%b%b/%h want 11/00000013", rv, er, rd); end
        f_one(BASE + 32'h2, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h00000013}) begin bad++; $display("FAIL f_mis got rv/er/rd=%b%b/%h want 11/00000013", rv, er, rd); end
        @(negedge clk);
        total++;
        if (bus.i_rvalid !== 1'b0) begin bad++; $display("FAIL f_idle got=%b want=0", bus.i_rvalid); end
    endtask

    task automatic test_read_first();
        logic g, rv, er; word_t rd;
        d_one(MEM_SW, 32'h40, 32'h11111111, g, rv, rd, er);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_op = MEM_SW; bus.d_addr = BASE + 32'h40; bus.d_wdata = 32'h22222222;
        bus.i_req = 1'b1; bus.i_addr = BASE + 32'h40;
        @(negedge clk);
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        total++;
        if (bus.i_rdata !== 32'h11111111) begin bad++; $display("FAIL rdfirst_old got=%h want=11111111", bus.i_rdata); end
        f_one(BASE + 32'h40, rv, rd, er);
        total++;
        if (rd !== 32'h22222222) begin bad++; $display("FAIL rdfirst_new got=%h want=22222222", rd); end
    endtask

`ifdef TCM_MISALIGNED_EN
    task automatic test_misaligned();
        logic g, g1, g2, rv, rv1, er; word_t rd;
        d_one(MEM_SW, 32'h30, 32'h0, g, rv, rd, er);
        d_one(MEM_SW, 32'h34, 32'h0, g, rv, rd, er);
        d_split(MEM_SW, 32'h31, 32'h11223344, g1, g2, rv1, rv, rd, er);
        total++;
        if ({g1, g2, rv1, rv, er, rd} !== {5'b10010, 32'h0}) begin bad++; $display("FAIL split_sw got g1/g2/rv1/rv/er/rd=%b%b%b%b%b/%h want 10010/0", g1, g2, rv1, rv, er, rd); end
        d_one(MEM_LW, 32'h30, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'h22334400) begin bad++; $display("FAIL mis_lw30 got=%h want=22334400", rd); end
        d_one(MEM_LW, 32'h34, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'h00000011) begin bad++; $display("FAIL mis_lw34 got=%h want=00000011", rd); end
        d_split(MEM_LW, 32'h31, 32'h0, g1, g2, rv1, rv, rd, er);
        total++;
        if ({g2, rv1, rv, er, rd} !== {4'b0010, 32'h11223344}) begin bad++; $display("FAIL split_lw got g2/rv1/rv/er/rd=%b%b%b%b/%h want 0010/11223344", g2, rv1, rv, er, rd); end
        d_split(MEM_LH, 32'h33, 32'h0, g1, g2, rv1, rv, rd, er);
        total++;
        if ({rv, rd} !== {1'b1, 32'h00001122}) begin bad++; $display("FAIL split_lh got rv/rd=%b/%h want 1/00001122", rv, rd); end
        d_one(MEM_LH, 32'h31, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b10, 32'h00003344}) begin bad++; $display("FAIL lh31 got rv/er/rd=%b%b/%h want 10/00003344", rv, er, rd); end
        d_one(MEM_LW, 32'hFFD, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL split_oor got rv/er/rd=%b%b/%h want 11/0", rv, er, rd); end
    endtask

    task automatic test_reset_mid();
        logic g, rv, er; word_t rd;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_op = MEM_LW; bus.d_addr = BASE + 32'h31;
        @(posedge clk);
        #1 resetn = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rv1 got=%b want=0", bus.d_rvalid); end
        @(negedge clk);
        total++;
        if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rv2 got=%b want=0", bus.d_rvalid); end
        resetn = 1'b1;
        #1;
        total++;
        if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b want=1", bus.d_gnt); end
        d_one(MEM_LW, 32'h30, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b10, 32'h22334400}) begin bad++; $display("FAIL rmid_lw got rv/er/rd=%b%b/%h want 10/22334400", rv, er, rd); end
    endtask
`else
    task automatic test_misaligned();
        logic g, rv, er; word_t rd;
        d_one(MEM_SW, 32'h30, 32'hCAFEF00D, g, rv, rd, er);
        d_one(MEM_LW, 32'h31, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL mis_lw31 got rv/er/rd=%b%b/%h want 11/0", rv, er, rd); end
        d_one(MEM_SW, 32'h31, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er} !== 2'b11) begin bad++; $display("FAIL mis_sw31 got rv/er=%b%b want 11", rv, er); end
        d_one(MEM_LW, 32'h30, 32'h0, g, rv, rd, er);
        total++;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_nowrite got=%h want=cafef00d", rd); end
        d_one(MEM_LH, 32'h31, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er} !== 2'b11) begin bad++; $display("FAIL mis_lh31 got rv/er=%b%b want 11", rv, er); end
        d_one(MEM_LH, 32'h33, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er} !== 2'b11) begin bad++; $display("FAIL mis_lh33 got rv/er=%b%b want 11", rv, er); end
        d_one(MEM_LH, 32'h32, 32'h0, g, rv, rd, er);
        total++;
        if ({er, rd} !== {1'b0, 32'hFFFFCAFE}) begin bad++; $display("FAIL lh32 got er/rd=%b/%h want 0/ffffcafe", er, rd); end
    endtask

    task automatic test_reset_mid();
        logic g, rv, er; word_t rd;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_op = MEM_LW; bus.d_addr = BASE + 32'h10;
        @(posedge clk);
        #1 resetn = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rv got=%b want=0", bus.d_rvalid); end
        resetn = 1'b1;
        #1;
        total++;
        if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b want=1", bus.d_gnt); end
        d_one(MEM_LW, 32'h10, 32'h0, g, rv, rd, er);
        total++;
        if ({rv, er, rd} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL rmid_lw got rv/er/rd=%b%b/%h want 10/deadbeef", rv, er, rd); end
    endtask
`endif

    initial begin
        bus.d_req = 1'b0; bus.d_op = MEM_LW; bus.d_addr = '0; bus.d_wdata = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        test_reset();
        test_word_byte();
        test_half();
        test_back_to_back();
        test_range();
        test_fetch();
        test_read_first();
        test_misaligned();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcm.md
# tcm

Parametrised tightly-coupled memory for the RV32 core: a dual-port block-RAM local memory with a request/grant/response data port and a pipelined instruction-fetch port. It replaces the fixed 1K-word local memory. It adds a configurable size and base address, and a request/response handshake. It can optionally split misaligned data accesses into two RAM beats. It sits between the core's memory stage / fetch stage and the inferred RAM.

## Interface
- ADDR_WIDTH, 10: word-address bits; capacity 2**ADDR_WIDTH words
- BASE_ADDR, 32'h00000000: byte base address; must be aligned to the capacity
- INIT_FILE, "boot.mem": RAM initialisation file
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- d_req  in  1  data request valid
- d_gnt  out  1  data request accepted this cycle when d_req & d_gnt
- d_op  in  mem_op_t  load/store kind
- d_addr  in  word_t  byte address
- d_wdata  in  word_t  store data, right-justified
- d_rvalid  out  1  response strobe, one per accepted request
- d_rdata  out  word_t  load result (sign/zero extended); 0 for stores and errors
- d_error  out  1  qualifies d_rvalid; out of range or unsupported misalignment
- i_req  in  1  fetch request, always accepted
- i_addr  in  word_t  fetch byte address
- i_rvalid  out  1  fetch response strobe
- i_rdata  out  word_t  instruction; NOP 32'h00000013 on error
- i_error  out  1  qualifies i_rvalid; misaligned or out of range

## Operation
- Offset = addr - BASE_ADDR. Out of range = any offset bit at [31:ADDR_WIDTH+2] set.
- Data FSM states:
  - IDLE: d_gnt=1. A request that needs one beat stays in IDLE. A crossing request moves to SPLIT.
  - SPLIT: d_gnt=0. The FSM accesses word A+1, then returns to IDLE.
- Lane steering: byte at lane a, half at lanes a..a+1, word at lanes 0..3. Store data is shifted left by 8*a and the byte-enables are set to match.
- Crossing access: word with a≠0, or half with a=3.
  - Beat 1 uses word A with lanes a..3.
  - Beat 2 uses word A+1 with the remaining low lanes.
  - Load bytes from the two beats are concatenated, then extended per d_op.
- Range is checked up front, on both A and A+1 for crossing accesses. Any error means no RAM write and no split.
- The instruction port is a read-only second RAM port with no write path.

## Timing
- Reset values:
  - d_gnt=0 while resetn low.
  - d_rvalid=0, d_rdata=0, d_error=0.
  - i_rvalid=0, i_rdata=32'h00000013, i_error=0.
  - FSM=IDLE.
- Single-beat access: accepted in cycle N, d_rvalid in N+1. Back-to-back requests sustain 1 per cycle.
- Split access: accepted in N, d_gnt=0 in N+1, d_rvalid in N+2. The store's second write occurs in N+1.
- Error response: d_rvalid in N+1 with d_error=1 and d_rdata=0.
- Fetch: i_req in N, i_rvalid in N+1. Fetches are fully pipelined and independent of the data port.
- Same-cycle data store and fetch to the same word: the fetch returns the old data (read-first).
- Reset mid-split: the FSM returns to IDLE and the pending response is dropped. A first-beat store write may have already committed.

## Configuration
- TCM_MISALIGNED_EN defined:
  - Crossing accesses split as above.
  - Non-crossing unnatural halves (a=1) complete in one beat.
- TCM_MISALIGNED_EN undefined:
  - The SPLIT state is removed and d_gnt=1 whenever out of reset.
  - Any word with a≠0 or half with a[0]=1 returns a d_error response with no write.

## Structure
- Package riscv: word_t, mem_op_t and the mem_op_t constants, NOP constant 32'h00000013, byte-enable typedef be_t (4 bits).
- Sub-module tcm_ram:
  - True dual-port inferred RAM with per-byte write enables and synchronous read-first outputs.
  - Parameters WIDTH, DEPTH, INIT_FILE.
- tcm holds the FSM, range checks, steering and response registers.

## Test plan
- SW 0xDEADBEEF at BASE+0x10, then LW 0x10 -> d_rvalid 1 cycle after each grant, rdata 0xDEADBEEF. LB at 0x13 -> 0xFFFFFFDE. LBU at 0x13 -> 0x000000DE.
- SH 0x8001 at 0x22, then LH 0x22 -> 0xFFFF8001, LHU -> 0x00008001. LW 0x20 -> upper half 0x8001, lower half unchanged.
- With TCM_MISALIGNED_EN:
  - SW 0x11223344 at 0x31 -> d_gnt low 1 cycle, response at N+2.
  - Then LW 0x30 -> 0x223344xx and LW 0x34 -> 0xxxxxxx11.
  - Then LW 0x31 -> 0x11223344.
- Without TCM_MISALIGNED_EN: LW 0x31 -> d_error=1, rdata 0, and memory unchanged.
- LW at BASE+(4<<ADDR_WIDTH) -> d_error. Fetch at the same address -> i_error, i_rdata 0x00000013. Fetch at 0x2 -> i_error.
- Assert resetn during SPLIT -> no d_rvalid. After release, d_gnt=1 and the next LW responds normally.
